// File: rtl/sram_byte_loader.sv
// ============================================================================
// Module : sram_byte_loader
// Packs a byte stream little-endian into words and writes DEPTH consecutive
// words from BASE_ADDR through a req/ack SRAM write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_byte_loader #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 196,
    parameter int ADDR_BIT  = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic [7:0]          din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                req,
    output logic                r0w1,
    output logic [ADDR_BIT-1:0] addr,
    output logic [WIDTH-1:0]    wdata,
    input  logic                ack,
    output logic                busy,
    output logic                done,
    output logic [ADDR_BIT-1:0] word_cnt
);

    localparam int NB    = WIDTH / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0]    c_LAST_LANE = IDX_W'(NB - 1);
    localparam logic [ADDR_BIT-1:0] c_LAST_WORD = ADDR_BIT'(DEPTH - 1);
    localparam logic [ADDR_BIT-1:0] c_BASE      = ADDR_BIT'(BASE_ADDR);

    generate
        if ((longint'(BASE_ADDR) + longint'(DEPTH) - 1) >= (longint'(1) << ADDR_BIT)) begin : g_addr_range_check
            $error("sram_byte_loader: BASE_ADDR + DEPTH - 1 does not fit in ADDR_BIT bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_REQ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic                 r_din_ready;
    logic                 r_req;
    logic                 r_busy;
    logic                 r_done;
    logic [ADDR_BIT-1:0]  r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [ADDR_BIT-1:0]  r_word_cnt;
    logic [IDX_W-1:0]     r_byte_idx;

    logic                 w_accept;
    logic                 w_last_lane;
    logic                 w_last_word;

    assign w_accept    = (r_state == S_FILL) && din_valid && r_din_ready;
    assign w_last_lane = (r_byte_idx == c_LAST_LANE);
    assign w_last_word = (r_word_cnt == c_LAST_WORD);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start)                   w_next_state = S_FILL;
            S_FILL: if (w_accept && w_last_lane) w_next_state = S_REQ;
            S_REQ:  if (ack)                     w_next_state = w_last_word ? S_DONE : S_FILL;
            S_DONE:                              w_next_state = S_IDLE;
            default:                             w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Control outputs are decoded from the next state so they are flops that
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_din_ready <= 1'b0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_din_ready <= (w_next_state == S_FILL);
            r_req       <= (w_next_state == S_REQ);
            r_busy      <= (w_next_state == S_FILL) || (w_next_state == S_REQ);
            r_done      <= (w_next_state == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_addr     <= c_BASE;
            r_wdata    <= '0;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= c_BASE;
                        r_word_cnt <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_wdata[8*r_byte_idx +: 8] <= din;
                        r_byte_idx <= w_last_lane ? '0 : r_byte_idx + IDX_W'(1);
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        r_word_cnt <= r_word_cnt + ADDR_BIT'(1);
                        r_byte_idx <= '0;
                        // The final address is kept so the last write stays visible.
                        if (!w_last_word) begin
                            r_addr <= r_addr + ADDR_BIT'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign din_ready = r_din_ready;
    assign req       = r_req;
    assign r0w1      = r_req;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign word_cnt  = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sram_byte_loader.sv
// ============================================================================
// Module : tb_sram_byte_loader
// Scoreboard bench: byte feeder, behavioural SRAM responder, done monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_byte_loader;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 196;
    localparam int ADDR_BIT = 12;
    localparam int NB       = WIDTH / 8;

    logic                clk = 1'b0;
    logic                rst_b;
    logic                start;
    logic [7:0]          din;
    logic                din_valid;
    logic                din_ready;
    logic                req;
    logic                r0w1;
    logic [ADDR_BIT-1:0] addr;
    logic [WIDTH-1:0]    wdata;
    logic                ack;
    logic                busy;
    logic                done;
    logic [ADDR_BIT-1:0] word_cnt;

    sram_byte_loader #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_BIT  (ADDR_BIT),
        .BASE_ADDR (0)
    ) u_dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .req       (req),
        .r0w1      (r0w1),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a word is queued once its last byte is handed over.
    logic [ADDR_BIT-1:0] q_addr[$];
    logic [WIDTH-1:0]    q_data[$];
    int                  m_lane;
    logic [WIDTH-1:0]    m_word;
    logic [ADDR_BIT-1:0] m_addr;
    logic [WIDTH-1:0]    mem [0:(1<<ADDR_BIT)-1];

    task automatic model_reset();
        m_lane = 0;
        m_word = '0;
        m_addr = '0;
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_word[8*m_lane +: 8] = b;
        m_lane++;
        if (m_lane == NB) begin
            q_addr.push_back(m_addr);
            q_data.push_back(m_word);
            m_addr++;
            m_lane = 0;
            m_word = '0;
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_word(input logic [7:0] first, input int w);
        logic [WIDTH-1:0] r;
        logic [7:0]       b;
        for (int i = 0; i < NB; i++) begin
            b = first + 8'(NB*w + i);
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    int cyc_cnt     = 0;
    int done_pulses = 0;
    int done_cyc    = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (done) begin done_pulses++; done_cyc = cyc_cnt; end

    task automatic feed(input int nbytes, input int gap, input logic [7:0] first);
        int         sent = 0;
        int         cyc  = 0;
        logic [7:0] b    = first;
        logic       acc;
        while (sent < nbytes && cyc < 20*nbytes + 200) begin
            din       = b;
            din_valid = (gap == 0) ? 1'b1 : ((cyc % 2) == 0);
            @(negedge clk);
            acc = din_valid && din_ready;
            if (acc) model_byte(b);
            @(posedge clk); #1;
            if (acc) begin sent++; b++; end
            cyc++;
        end
        din_valid = 1'b0;
        chk("feed_bytes_sent", sent, nbytes);
    endtask

    task automatic respond(input int nwords, input int delay);
        for (int w = 0; w < nwords; w++) begin
            int                  t = 0;
            logic [ADDR_BIT-1:0] a0;
            logic [WIDTH-1:0]    d0;
            @(negedge clk);
            while (!req && t < 200) begin @(negedge clk); t++; end
            if (!req) begin
                chk("req_timeout", 32'(req), 32'd1);
                return;
            end
            chk("r0w1_with_req", 32'(r0w1), 32'd1);
            chk("din_ready_in_req", 32'(din_ready), 32'd0);
            a0 = addr;
            d0 = wdata;
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                chk("req_held", 32'(req), 32'd1);
                chk("addr_stable", 32'(addr), 32'(a0));
                chk("wdata_stable", wdata, d0);
            end
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            mem[a0] = d0;
            if (q_addr.size() == 0) begin
                chk("sb_word_expected", 32'(q_addr.size()), 32'd1);
            end else begin
                chk("sb_addr", 32'(a0), 32'(q_addr.pop_front()));
                chk("sb_wdata", d0, q_data.pop_front());
            end
            chk("req_drop_after_ack", 32'(req), 32'd0);
        end
    endtask

    task automatic run_load(input int gap, input int delay, input logic [7:0] first,
                            input bit poke_start, output int lat);
        int dp0;
        int start_cyc;
        dp0 = done_pulses;
        model_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc_cnt;
        chk("busy_after_start", 32'(busy), 32'd1);
        fork
            feed(NB*DEPTH, gap, first);
            respond(DEPTH, delay);
            if (poke_start) begin
                repeat (37) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("done_once", 32'(done_pulses - dp0), 32'd1);
        chk("word_cnt_final", 32'(word_cnt), 32'(DEPTH));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("sb_drained", 32'(q_addr.size()), 32'd0);
        lat = done_cyc - start_cyc;
    endtask

    task automatic check_reset_outputs(input string phase);
        chk({phase, "_req"},       32'(req),       32'd0);
        chk({phase, "_r0w1"},      32'(r0w1),      32'd0);
        chk({phase, "_din_ready"}, 32'(din_ready), 32'd0);
        chk({phase, "_busy"},      32'(busy),      32'd0);
        chk({phase, "_done"},      32'(done),      32'd0);
        chk({phase, "_addr"},      32'(addr),      32'd0);
        chk({phase, "_word_cnt"},  32'(word_cnt),  32'd0);
        chk({phase, "_wdata"},     wdata,          32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int dp0;

        rst_b     = 1'b0;
        start     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        ack       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = ~start; din_valid = ~din_valid; ack = ~ack; din = 8'(i*37);
        end
        @(negedge clk);
        check_reset_outputs("rst_init");
        start = 1'b0; din_valid = 1'b0; ack = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;

        // Back-to-back bytes, ack in the first request cycle.
        run_load(0, 0, 8'h01, 1'b0, lat);
        chk("loadA_mem0", mem[0], 32'h04030201);
        chk("loadA_mem_last", mem[DEPTH-1], exp_word(8'h01, DEPTH-1));
        chk("loadA_last_addr", 32'(addr), 32'(DEPTH-1));
        // done appears in the cycle after the final ack edge, (NB+1)*DEPTH edges after start.
        chk("loadA_latency", 32'(lat), 32'((NB+1)*DEPTH));

        // Ack outside a request must not count.
        dp0 = done_pulses;
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_word_cnt", 32'(word_cnt), 32'(DEPTH));
        chk("idle_ack_req", 32'(req), 32'd0);
        chk("idle_ack_no_done", 32'(done_pulses - dp0), 32'd0);
        @(posedge clk); #1;

        run_load(0, 3, 8'h40, 1'b0, lat);
        chk("loadB_mem0", mem[0], exp_word(8'h40, 0));
        chk("loadB_mem77", mem[77], exp_word(8'h40, 77));
        chk("loadB_mem_last", mem[DEPTH-1], exp_word(8'h40, DEPTH-1));
        @(posedge clk); #1;

        // din_valid toggling, one-cycle ack delay, stray start mid-load.
        run_load(1, 1, 8'h90, 1'b1, lat);
        chk("loadC_mem0", mem[0], exp_word(8'h90, 0));
        chk("loadC_mem5", mem[5], exp_word(8'h90, 5));
        chk("loadC_mem_last", mem[DEPTH-1], exp_word(8'h90, DEPTH-1));
        @(posedge clk); #1;

        // Reset after two bytes of word 5.
        model_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            feed(5*NB + 2, 0, 8'h55);
            respond(5, 0);
        join
        chk("midrst_word_cnt_before", 32'(word_cnt), 32'd5);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_b = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        start = 1'b1; din_valid = 1'b1; ack = 1'b1; din = 8'hEE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid_held");
        start = 1'b0; din_valid = 1'b0; ack = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;

        run_load(0, 0, 8'hA0, 1'b0, lat);
        chk("loadD_mem0", mem[0], 32'hA3A2A1A0);
        chk("loadD_mem5", mem[5], exp_word(8'hA0, 5));
        chk("loadD_mem_last", mem[DEPTH-1], exp_word(8'hA0, DEPTH-1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
